// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60 timing, framebuffer geometry
// and the pixel colour word used by the fetch and drawing sides.
package vga_pkg;

  localparam int HD      = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = HD + H_FP + H_SYNC + H_BP;

  localparam int VD      = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = VD + V_FP + V_SYNC + V_BP;

  localparam int SCALE_SHIFT = 2;
  localparam int FB_W        = HD >> SCALE_SHIFT;
  localparam int FB_H        = VD >> SCALE_SHIFT;
  localparam int ADDR_W      = 15;
  localparam int COLOR_W     = 3;
  localparam int RD_LAT      = 1;

  typedef logic [COLOR_W-1:0] rgb_t;

endpackage

// File: rtl/vga_delay_line.sv
// Reset-valued shift register; q is d delayed by DEPTH clocks.
// Ports: clk, rst (async, active-high), d in, q out.
module vga_delay_line #(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_fb_fetch.sv
// Framebuffer fetch: maps vga_sync coordinates to reads of a
// double-buffered, downscaled BRAM framebuffer and drives RGB and
// pixel-aligned syncs to the pins; swaps banks at vblank entry.
// Ports: clk, rst (async, active-high); pixel_x/pixel_y and
// hsync_in/vsync_in from vga_sync; fb_rd_en/fb_addr/fb_data to the
// BRAM; swap_req/swap_ack/front_bank to the drawer; frame_start,
// hsync_out, vsync_out, rgb to the pins.
module vga_fb_fetch
  import vga_pkg::*;
#(
  parameter int P_HD          = HD,
  parameter int P_VD          = VD,
  parameter int P_SCALE_SHIFT = SCALE_SHIFT,
  parameter int P_FB_W        = FB_W,
  parameter int P_ADDR_W      = ADDR_W,
  parameter int P_COLOR_W     = COLOR_W,
  parameter int P_RD_LAT      = RD_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  output logic                 fb_rd_en,
  output logic [P_ADDR_W:0]    fb_addr,
  input  logic [P_COLOR_W-1:0] fb_data,
  input  logic                 swap_req,
  output logic                 swap_ack,
  output logic                 front_bank,
  output logic                 frame_start,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic [P_COLOR_W-1:0] rgb
);

  // Address stage + BRAM latency; rgb register closes the pipe.
  localparam int DLY = P_RD_LAT + 1;

  localparam logic [9:0] HD_C = 10'(P_HD);
  localparam logic [9:0] VD_C = 10'(P_VD);

  // row * FB_W as a constant shift-add: one adder per set bit
  // of FB_W (160 = 128 + 32), no multiplier.
  function automatic logic [P_ADDR_W-1:0] row_base(
    input logic [P_ADDR_W-1:0] r
  );
    logic [P_ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < P_ADDR_W; i++)
      if (P_FB_W[i])
        acc = acc + (r << i);
    return acc;
  endfunction

  logic                active;
  logic                vblank;
  logic [P_ADDR_W-1:0] row_w;
  logic [P_ADDR_W-1:0] col_w;
  logic [P_ADDR_W-1:0] lin;
  logic                active_d;
  logic                pending;

  assign active = (pixel_x < HD_C) && (pixel_y < VD_C);
  assign vblank = (pixel_x == 10'd0) && (pixel_y == VD_C);

  assign row_w = P_ADDR_W'(pixel_y >> P_SCALE_SHIFT);
  assign col_w = P_ADDR_W'(pixel_x >> P_SCALE_SHIFT);
  assign lin   = row_base(row_w) + col_w;

  // Stage A: address is held while blanked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_rd_en <= 1'b0;
      fb_addr  <= '0;
    end else begin
      fb_rd_en <= active;
      if (active)
        fb_addr <= {front_bank, lin};
    end
  end

  // hsync_in already lags the coordinates by one clock.
  vga_delay_line #(
    .WIDTH   (2),
    .DEPTH   (DLY),
    .RST_VAL (2'b11)
  ) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .d   ({hsync_in, vsync_in}),
    .q   ({hsync_out, vsync_out})
  );

  vga_delay_line #(
    .WIDTH   (1),
    .DEPTH   (DLY),
    .RST_VAL (1'b0)
  ) u_act_dly (
    .clk (clk),
    .rst (rst),
    .d   (active),
    .q   (active_d)
  );

  // Stage C: blanking applied at the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rgb <= '0;
    else
      rgb <= active_d ? fb_data : '0;
  end

  // A request landing on the vblank clock is taken at once;
  // one arriving on the ack clock re-arms for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_bank  <= 1'b0;
      pending     <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= vblank;
      swap_ack    <= 1'b0;
      if (vblank && (pending || swap_req)) begin
        front_bank <= ~front_bank;
        pending    <= 1'b0;
        swap_ack   <= 1'b1;
      end else if (swap_req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Directed bench for vga_fb_fetch: address table, per-pixel
// scoreboard for rgb/sync alignment, and bank-swap sequences.
module tb_vga_fb_fetch;

  logic        clk;
  logic        rst;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        hsync_in;
  logic        vsync_in;
  logic        fb_rd_en;
  logic [15:0] fb_addr;
  logic [2:0]  fb_data;
  logic        swap_req;
  logic        swap_ack;
  logic        front_bank;
  logic        frame_start;
  logic        hsync_out;
  logic        vsync_out;
  logic [2:0]  rgb;

  vga_fb_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .fb_rd_en    (fb_rd_en),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .front_bank  (front_bank),
    .frame_start (frame_start),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .rgb         (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model, RD_LAT=1, data = low address bits.
  always @(posedge clk) fb_data <= fb_addr[2:0];

  int total = 0;
  int bad   = 0;
  int fs_cnt = 0;
  int ack_cnt = 0;
  int ack_lone = 0;
  int hx[3];
  int hy[3];

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_start) fs_cnt++;
      if (swap_ack) ack_cnt++;
      if (swap_ack && !frame_start) ack_lone++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic bit is_act(input int x, input int y);
    return (x < 640) && (y < 480);
  endfunction

  function automatic int exp_rgb(input int x, input int y);
    if (!is_act(x, y)) return 0;
    return ((y / 4) * 160 + x / 4) % 8;
  endfunction

  function automatic int hs(input int x);
    return (x >= 656 && x <= 751) ? 0 : 1;
  endfunction

  function automatic int vs(input int y);
    return (y >= 490 && y <= 491) ? 0 : 1;
  endfunction

  task automatic idle_inputs();
    pixel_x  = 10'd799;
    pixel_y  = 10'd524;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    swap_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hx[i] = 799;
      hy[i] = 524;
    end
  endtask

  // One pixel clock: check outputs of the coords 3 (rgb/sync)
  // and 1 (rd_en) steps ago, then drive the next coords.
  task automatic step(input int x, input int y, input bit req);
    @(negedge clk);
    chk($sformatf("rgb@%0d,%0d", hx[2], hy[2]),
        rgb, exp_rgb(hx[2], hy[2]));
    chk($sformatf("hsync@%0d,%0d", hx[2], hy[2]),
        hsync_out, hs(hx[2]));
    chk($sformatf("vsync@%0d,%0d", hx[2], hy[2]),
        vsync_out, vs(hy[2]));
    chk($sformatf("rd_en@%0d,%0d", hx[0], hy[0]),
        fb_rd_en, is_act(hx[0], hy[0]));
    hsync_in = hs(hx[0]) != 0;
    vsync_in = vs(hy[0]) != 0;
    hx[2] = hx[1]; hy[2] = hy[1];
    hx[1] = hx[0]; hy[1] = hy[0];
    hx[0] = x;     hy[0] = y;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    swap_req = req;
  endtask

  task automatic run_line(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) step(x, y, 1'b0);
  endtask

  task automatic vblank(input bit rv, input bit ra,
                        input int b_pre, input int b_post,
                        input int acks);
    int f0;
    int a0;
    f0 = fs_cnt;
    a0 = ack_cnt;
    step(799, 479, 1'b0);
    step(0, 480, rv);
    chk("bank_pre", front_bank, b_pre);
    @(posedge clk); #1;
    chk("bank_post", front_bank, b_post);
    step(1, 480, ra);
    step(2, 480, 1'b0);
    chk("frame_start_cnt", fs_cnt - f0, 1);
    chk("swap_ack_cnt", ack_cnt - a0, acks);
  endtask

  typedef struct {
    int x;
    int y;
    int addr;
    bit en;
  } vec_t;

  vec_t tv[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{0,   0,   0,     1'b1};
    tv[1] = '{3,   3,   0,     1'b1};
    tv[2] = '{4,   0,   1,     1'b1};
    tv[3] = '{639, 0,   159,   1'b1};
    tv[4] = '{0,   4,   160,   1'b1};
    tv[5] = '{639, 479, 19199, 1'b1};
    tv[6] = '{700, 10,  19199, 1'b0};
    tv[7] = '{5,   480, 19199, 1'b0};
    tv[8] = '{8,   8,   322,   1'b1};
    tv[9] = '{100, 200, 8025,  1'b1};

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", hsync_out, 1);
    chk("rst_vsync", vsync_out, 1);
    chk("rst_rd_en", fb_rd_en, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_bank", front_bank, 0);
    chk("rst_ack", swap_ack, 0);
    chk("rst_fs", frame_start, 0);
    rst = 1'b0;

    foreach (tv[i]) begin
      step(tv[i].x, tv[i].y, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("addr_v%0d", i), fb_addr, tv[i].addr);
      chk($sformatf("en_v%0d", i), fb_rd_en, tv[i].en);
    end

    run_line(0, 0, 799);
    run_line(479, 600, 799);
    run_line(489, 0, 3);
    run_line(490, 0, 3);
    run_line(491, 0, 3);
    run_line(492, 0, 3);

    vblank(1'b0, 1'b0, 0, 0, 0);

    step(0, 100, 1'b1);
    run_line(100, 1, 8);
    vblank(1'b0, 1'b0, 0, 1, 1);
    step(0, 0, 1'b0);
    @(posedge clk); #1;
    chk("addr_bank1_00", fb_addr, 32768);
    step(639, 479, 1'b0);
    @(posedge clk); #1;
    chk("addr_bank1_last", fb_addr, 32768 + 19199);

    vblank(1'b1, 1'b0, 1, 0, 1);

    step(0, 50, 1'b1);
    step(1, 50, 1'b0);
    step(0, 60, 1'b1);
    step(1, 60, 1'b0);
    vblank(1'b0, 1'b0, 0, 1, 1);
    vblank(1'b0, 1'b0, 1, 1, 0);

    step(0, 200, 1'b1);
    vblank(1'b0, 1'b1, 1, 0, 1);
    vblank(1'b0, 1'b0, 0, 1, 1);

    step(0, 300, 1'b1);
    step(5, 300, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_rgb", rgb, 0);
    chk("mrst_hsync", hsync_out, 1);
    chk("mrst_vsync", vsync_out, 1);
    chk("mrst_rd_en", fb_rd_en, 0);
    chk("mrst_bank", front_bank, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    run_line(300, 0, 10);
    vblank(1'b0, 1'b0, 0, 0, 0);
    step(0, 0, 1'b0);
    @(posedge clk); #1;
    chk("addr_after_rst", fb_addr, 0);
    run_line(0, 1, 6);

    chk("ack_without_fs", ack_lone, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
